// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, stereo sample type and frame bit selection for the I2S path
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int SLOT_BITS = 32;
  localparam int FRAME_BITS = 64;
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] l;
    logic signed [SAMPLE_W-1:0] r;
  } stereo_sample_t;
  function automatic logic frame_bit(stereo_sample_t s, logic [5:0] bc, logic lj);
    logic [FRAME_BITS-1:0] frame;
    frame = {s.l, {(SLOT_BITS-SAMPLE_W){1'b0}}, s.r, {(SLOT_BITS-SAMPLE_W){1'b0}}};
    // I2S index 64-bc wraps to 0 at bc=0, landing on padding: that is the one-bit delay
    return lj ? frame[~bc] : frame[6'(7'd64 - 7'(bc))];
  endfunction
endpackage

// File: rtl/audio_sclk_gen.sv
// audio_sclk_gen: SCLK divider, 64-bit frame counter, LRCK and fall/frame-load strobes
module audio_sclk_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       sclk,
  output logic       lrck,
  output logic [5:0] bit_nxt,
  output logic       fall,
  output logic       frame_load
);
  logic [7:0] div_q, div_d;
  logic       sclk_q, sclk_d;
  logic [5:0] bit_q, bit_d;
  logic       wrap;
  always_comb begin
    wrap = div_q == 8'(SCLK_DIV - 1);
    fall = wrap && sclk_q;
    frame_load = fall && bit_q == 6'd63;
    div_d = wrap ? 8'd0 : div_q + 8'd1;
    sclk_d = wrap ? ~sclk_q : sclk_q;
    bit_d = fall ? bit_q + 6'd1 : bit_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      sclk_q <= 1'b0;
      bit_q <= '0;
    end else begin
      div_q <= div_d;
      sclk_q <= sclk_d;
      bit_q <= bit_d;
    end
  end
  assign sclk = sclk_q;
  assign lrck = bit_q[5];
  assign bit_nxt = bit_d;
endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: stereo sample holding register and I2S/left-justified serialiser with status pulses
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int SCLK_DIV = 2,
  parameter bit LEFT_JUSTIFIED = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  input  logic        mute,
  output logic        sample_req,
  output logic        underrun,
  output logic        overrun,
  output logic        i2s_sclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata
);
  stereo_sample_t holding_q, holding_d, shift_q, shift_d;
  logic pending_q, pending_d, sdata_q, sdata_d;
  logic req_q, req_d, under_q, under_d, over_q, over_d;
  logic fall, frame_load;
  logic [5:0] bit_nxt;
  audio_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .clk       (clk),
    .reset     (reset),
    .sclk      (i2s_sclk),
    .lrck      (i2s_lrck),
    .bit_nxt   (bit_nxt),
    .fall      (fall),
    .frame_load(frame_load)
  );
  always_comb begin
    holding_d = sample_valid ? stereo_sample_t'({sample_l, sample_r}) : holding_q;
    pending_d = sample_valid || (pending_q && !frame_load);
    // load reads holding_q, so a same-cycle capture goes out next frame
    shift_d = frame_load ? (mute ? stereo_sample_t'('0) : holding_q) : shift_q;
    sdata_d = fall ? frame_bit(shift_d, bit_nxt, LEFT_JUSTIFIED) : sdata_q;
    req_d = frame_load;
    under_d = frame_load && !pending_q;
    over_d = sample_valid && pending_q && !frame_load;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      holding_q <= '0;
      shift_q <= '0;
      pending_q <= 1'b0;
      sdata_q <= 1'b0;
      req_q <= 1'b0;
      under_q <= 1'b0;
      over_q <= 1'b0;
    end else begin
      holding_q <= holding_d;
      shift_q <= shift_d;
      pending_q <= pending_d;
      sdata_q <= sdata_d;
      req_q <= req_d;
      under_q <= under_d;
      over_q <= over_d;
    end
  end
  assign sample_req = req_q;
  assign underrun = under_q;
  assign overrun = over_q;
  assign i2s_sdata = sdata_q;
endmodule
